// File: rtl/dram_cmd_sched.sv
// rtl/dram_cmd_sched.sv - single-outstanding DRAM command scheduler with open-row table and refresh
module dram_cmd_sched #(
  parameter int ROW_BITS = 16,
  parameter int COL_BITS = 10,
  parameter int T_RP     = 4,
  parameter int T_RCD    = 4,
  parameter int T_CL     = 4,
  parameter int T_RFC    = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_bg,
  input  logic [1:0]          req_bank,
  input  logic [ROW_BITS-1:0] req_row,
  input  logic [COL_BITS-1:0] req_col,
  input  logic                ref_req,
  output logic                ref_ack,
  output logic                cmd_valid,
  output logic [2:0]          cmd,
  output logic [1:0]          cmd_bg,
  output logic [1:0]          cmd_bank,
  output logic [ROW_BITS-1:0] cmd_row,
  output logic [COL_BITS-1:0] cmd_col,
  output logic [1:0]          row_stat,
  output logic                done
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_W_RP, S_ACT, S_W_RCD, S_COL, S_W_CL,
    S_PREA, S_W_RPA, S_REF, S_W_RFC
  } state_t;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_PRE = 3'd2, C_RD = 3'd3,
                         C_WR = 3'd4, C_REF = 3'd5, C_PREA = 3'd6;

  // Pre-command waits end one cycle early so the next command lands exactly T after the last.
  localparam logic [7:0] RP_LOAD  = 8'(T_RP - 1);
  localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 1);
  // CAS and refresh waits run their full length so the completion pulse falls on the last cycle.
  localparam logic [7:0] CL_LOAD  = 8'(T_CL);
  localparam logic [7:0] RFC_LOAD = 8'(T_RFC);

  state_t                state, next_state;
  logic [7:0]            cnt;
  logic [15:0]           tbl_valid;
  logic [ROW_BITS-1:0]   tbl_row [16];
  logic                  lat_write;
  logic [1:0]            lat_bg, lat_bank;
  logic [ROW_BITS-1:0]   lat_row;
  logic [COL_BITS-1:0]   lat_col;
  logic [3:0]            req_idx, lat_idx;
  logic                  accept, req_hit, wait_last;

  assign req_idx   = {req_bg, req_bank};
  assign lat_idx   = {lat_bg, lat_bank};
  assign req_ready = (state == S_IDLE) && !ref_req && !RST;
  assign accept    = req_valid && req_ready;
  assign req_hit   = tbl_valid[req_idx] && (tbl_row[req_idx] == req_row);
  assign wait_last = (cnt <= 8'd1);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and command/pulse outputs decoded from the current state.
  always_comb begin
    next_state = state;
    cmd_valid  = 1'b0;
    cmd        = C_NOP;
    cmd_bg     = '0;
    cmd_bank   = '0;
    cmd_row    = '0;
    cmd_col    = '0;
    done       = 1'b0;
    ref_ack    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ref_req)     next_state = (|tbl_valid) ? S_PREA : S_REF;
        else if (accept) next_state = req_hit ? S_COL : (tbl_valid[req_idx] ? S_PRE : S_ACT);
      end
      S_PRE: begin
        cmd_valid  = 1'b1;
        cmd        = C_PRE;
        cmd_bg     = lat_bg;
        cmd_bank   = lat_bank;
        next_state = (T_RP == 1) ? S_ACT : S_W_RP;
      end
      S_W_RP:  if (wait_last) next_state = S_ACT;
      S_ACT: begin
        cmd_valid  = 1'b1;
        cmd        = C_ACT;
        cmd_bg     = lat_bg;
        cmd_bank   = lat_bank;
        cmd_row    = lat_row;
        next_state = (T_RCD == 1) ? S_COL : S_W_RCD;
      end
      S_W_RCD: if (wait_last) next_state = S_COL;
      S_COL: begin
        cmd_valid  = 1'b1;
        cmd        = lat_write ? C_WR : C_RD;
        cmd_bg     = lat_bg;
        cmd_bank   = lat_bank;
        cmd_col    = lat_col;
        next_state = S_W_CL;
      end
      S_W_CL: begin
        if (wait_last) begin
          done       = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_PREA: begin
        cmd_valid  = 1'b1;
        cmd        = C_PREA;
        next_state = (T_RP == 1) ? S_REF : S_W_RPA;
      end
      S_W_RPA: if (wait_last) next_state = S_REF;
      S_REF: begin
        cmd_valid  = 1'b1;
        cmd        = C_REF;
        next_state = S_W_RFC;
      end
      S_W_RFC: begin
        if (wait_last) begin
          ref_ack    = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Wait counter: loaded when a command issues, counts down through the following wait state.
  always_ff @(posedge CLK) begin
    if (RST) cnt <= 8'd0;
    else begin
      case (state)
        S_PRE, S_PREA: cnt <= RP_LOAD;
        S_ACT:         cnt <= RCD_LOAD;
        S_COL:         cnt <= CL_LOAD;
        S_REF:         cnt <= RFC_LOAD;
        default:       if (cnt != 8'd0) cnt <= cnt - 8'd1;
      endcase
    end
  end

  // Open-row table tracks what each bank holds after ACT/PRE/PREA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tbl_valid <= '0;
      for (int i = 0; i < 16; i++) tbl_row[i] <= '0;
    end else begin
      case (state)
        S_ACT: begin
          tbl_valid[lat_idx] <= 1'b1;
          tbl_row[lat_idx]   <= lat_row;
        end
        S_PRE:   tbl_valid[lat_idx] <= 1'b0;
        S_PREA:  tbl_valid <= '0;
        default: ;
      endcase
    end
  end

  // Request latch and row classification captured at the accept handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lat_write <= 1'b0;
      lat_bg    <= '0;
      lat_bank  <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      row_stat  <= 2'b00;
    end else if (accept) begin
      lat_write <= req_write;
      lat_bg    <= req_bg;
      lat_bank  <= req_bank;
      lat_row   <= req_row;
      lat_col   <= req_col;
      row_stat  <= req_hit ? 2'b01 : (tbl_valid[req_idx] ? 2'b11 : 2'b10);
    end
  end

endmodule
